// File: rtl/gelato_compute_alu.sv
// SIMD integer ALU: latches a warp task and computes LANES threads per cycle.
// Define GELATO_ALU_MUL_EN to make op 10 a per-thread MUL (otherwise op 10 is illegal).
module gelato_compute_alu #(
  parameter int THREAD_NUM = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rdy,
  input  logic                             task_valid,
  input  logic [3:0]                       task_op,
  input  logic [THREAD_NUM*DATA_WIDTH-1:0] task_rs1,
  input  logic [THREAD_NUM*DATA_WIDTH-1:0] task_rs2,
  output logic                             task_done,
  output logic [THREAD_NUM*DATA_WIDTH-1:0] task_rd,
  output logic                             task_err,
  output logic                             busy
);

  localparam int CHUNKS = THREAD_NUM / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int SHW    = $clog2(DATA_WIDTH);
  localparam int BUS_W  = THREAD_NUM * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
`ifdef GELATO_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_LAST = 4'd10;
`else
  localparam logic [3:0] OP_LAST = 4'd9;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      chunk_q, chunk_d;
  logic               done_d, err_d;
  logic [BUS_W-1:0]   rd_d;
  logic [3:0]         op_q;
  logic [BUS_W-1:0]   rs1_q, rs2_q;
  logic               op_illegal;

  // Single-thread result; illegal opcodes fall through to zero.
  function automatic logic [DATA_WIDTH-1:0] alu_lane(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [SHW-1:0]               sh;
    logic signed [DATA_WIDTH-1:0] sa, sb;
    sh = b[SHW-1:0];
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  alu_lane = a + b;
      OP_SUB:  alu_lane = a - b;
      OP_AND:  alu_lane = a & b;
      OP_OR:   alu_lane = a | b;
      OP_XOR:  alu_lane = a ^ b;
      OP_SLL:  alu_lane = a << sh;
      OP_SRL:  alu_lane = a >> sh;
      OP_SRA:  alu_lane = sa >>> sh;
      OP_SLT:  alu_lane = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLTU: alu_lane = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
`ifdef GELATO_ALU_MUL_EN
      OP_MUL:  alu_lane = a * b;
`endif
      default: alu_lane = '0;
    endcase
  endfunction

  assign op_illegal = (op_q > OP_LAST);
  assign busy       = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n)   state_q <= S_IDLE;
    else if (rdy) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (task_valid) state_d = S_BUSY;
      S_BUSY:  if (chunk_q == LAST_CHUNK) state_d = S_DONE;
      S_DONE:  if (!task_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    chunk_d = chunk_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_d    = task_rd;
    case (state_q)
      S_IDLE: if (task_valid) chunk_d = '0;
      S_BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          rd_d[(int'(chunk_q) * LANES + l) * DATA_WIDTH +: DATA_WIDTH] =
            alu_lane(op_q,
                     rs1_q[(int'(chunk_q) * LANES + l) * DATA_WIDTH +: DATA_WIDTH],
                     rs2_q[(int'(chunk_q) * LANES + l) * DATA_WIDTH +: DATA_WIDTH]);
        end
        chunk_d = chunk_q + CW'(1);
        if (chunk_q == LAST_CHUNK) begin
          chunk_d = '0;
          done_d  = 1'b1;
          err_d   = op_illegal;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chunk_q   <= '0;
      task_done <= 1'b0;
      task_err  <= 1'b0;
      task_rd   <= '0;
    end else if (rdy) begin
      chunk_q   <= chunk_d;
      task_done <= done_d;
      task_err  <= err_d;
      task_rd   <= rd_d;
    end
  end

  // Operands are captured once at acceptance so the scheduler may change its bus afterwards.
  always_ff @(posedge clk) begin
    if (rst_n && rdy && state_q == S_IDLE && task_valid) begin
      op_q  <= task_op;
      rs1_q <= task_rs1;
      rs2_q <= task_rs2;
    end
  end

endmodule

// File: tb/tb_gelato_compute_alu.sv
// Directed self-checking bench for gelato_compute_alu at default parameters.
module tb_gelato_compute_alu;

  localparam int TN = 32;
  localparam int DW = 32;
  localparam int N  = TN * DW;

  logic          clk = 1'b0;
  logic          rst_n, rdy, task_valid;
  logic [3:0]    task_op;
  logic [N-1:0]  task_rs1, task_rs2;
  logic          task_done, task_err, busy;
  logic [N-1:0]  task_rd;

  int checks = 0;
  int errors = 0;

  gelato_compute_alu #(.THREAD_NUM(TN), .DATA_WIDTH(DW), .LANES(8)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .task_valid(task_valid), .task_op(task_op),
    .task_rs1(task_rs1), .task_rs2(task_rs2), .task_done(task_done), .task_rd(task_rd),
    .task_err(task_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] bcast(input logic [DW-1:0] v);
    return {TN{v}};
  endfunction

  // Runs one task to completion; scrambles the input bus after acceptance.
  task automatic do_task(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] rd, output logic err, output int cyc);
    task_op = op; task_rs1 = a; task_rs2 = b; task_valid = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 1) begin
        task_rs1 = ~a; task_rs2 = ~b; task_op = ~op;
      end
    end while (!task_done && cyc < 30);
    rd = task_rd; err = task_err;
    task_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; task_valid = 1'b1; task_op = 4'd0;
    task_rs1 = bcast(32'h1); task_rs2 = bcast(32'h2);
    repeat (2) tick();
    checks++; if (task_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", task_done); end
    checks++; if (task_rd !== '0) begin errors++; $display("FAIL reset_rd got %h want 0", task_rd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (task_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", task_err); end
    task_valid = 1'b0; rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b want 0", busy); end
  endtask

  task automatic test_add();
    logic [N-1:0] a, exp;
    int cyc;
    for (int t = 0; t < TN; t++) begin
      a[t*DW +: DW]   = DW'(t);
      exp[t*DW +: DW] = DW'(t + 5);
    end
    task_op = 4'd0; task_rs1 = a; task_rs2 = bcast(32'd5); task_valid = 1'b1;
    cyc = 0;
    do begin tick(); cyc++; end while (!task_done && cyc < 30);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL add_latency got %0d want 5", cyc); end
    checks++; if (task_rd !== exp) begin errors++; $display("FAIL add_rd got %h want %h", task_rd, exp); end
    checks++; if (task_err !== 1'b0) begin errors++; $display("FAIL add_err got %b want 0", task_err); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (task_done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL add_hold_valid cycle %0d done %b busy %b want done 0 busy 1", i, task_done, busy);
      end
    end
    checks++; if (task_rd !== exp) begin errors++; $display("FAIL add_rd_stable got %h want %h", task_rd, exp); end
    task_valid = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_to_idle busy got %b want 0", busy); end
  endtask

  task automatic test_wrap_sign();
    logic [3:0]    ops [10] = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd7, 4'd6, 4'd5, 4'd2, 4'd3, 4'd4};
    logic [DW-1:0] av  [10] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                32'h80000000, 32'h1, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0};
    logic [DW-1:0] bv  [10] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h4,
                                32'h4, 32'h24, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00};
    logic [DW-1:0] ev  [10] = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hF8000000,
                                32'h08000000, 32'h10, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0};
    logic [N-1:0] rd;
    logic err;
    int cyc;
    for (int i = 0; i < 10; i++) begin
      do_task(ops[i], bcast(av[i]), bcast(bv[i]), rd, err, cyc);
      checks++;
      if (rd !== bcast(ev[i]) || err !== 1'b0 || cyc !== 5) begin
        errors++;
        $display("FAIL op%0d_row%0d lane0 got %h err %b cyc %0d want %h err 0 cyc 5",
                 ops[i], i, rd[DW-1:0], err, cyc, ev[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] a, b, exp;
    int cyc;
    for (int t = 0; t < TN; t++) begin
      a[t*DW +: DW]   = DW'(t * 3);
      b[t*DW +: DW]   = DW'(t);
      exp[t*DW +: DW] = DW'(t * 4);
    end
    task_op = 4'd0; task_rs1 = a; task_rs2 = b; task_valid = 1'b1;
    tick(); tick();
    task_valid = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (task_done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL stall_hold cycle %0d done %b busy %b want done 0 busy 1", i, task_done, busy);
      end
    end
    rdy = 1'b1;
    cyc = 5;
    do begin tick(); cyc++; end while (!task_done && cyc < 40);
    checks++; if (cyc !== 8) begin errors++; $display("FAIL stall_latency got %0d want 8", cyc); end
    checks++; if (task_rd !== exp) begin errors++; $display("FAIL stall_rd got %h want %h", task_rd, exp); end
    rdy = 1'b0;
    tick();
    checks++; if (task_done !== 1'b1) begin errors++; $display("FAIL stall_done_hold got %b want 1", task_done); end
    rdy = 1'b1;
    tick();
    checks++;
    if (task_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_release done %b busy %b want 0 0", task_done, busy);
    end
  endtask

  task automatic test_illegal();
    logic [N-1:0] rd;
    logic err;
    int cyc;
`ifdef GELATO_ALU_MUL_EN
    logic [N-1:0] exp_mul = bcast(32'd42);
    logic         exp_err = 1'b0;
`else
    logic [N-1:0] exp_mul = '0;
    logic         exp_err = 1'b1;
`endif
    do_task(4'd10, bcast(32'd7), bcast(32'd6), rd, err, cyc);
    checks++;
    if (rd !== exp_mul || err !== exp_err || cyc !== 5) begin
      errors++; $display("FAIL op10_7x6 lane0 got %h err %b cyc %0d want %h err %b cyc 5", rd[DW-1:0], err, cyc, exp_mul[DW-1:0], exp_err);
    end
    do_task(4'd10, bcast(32'h10000), bcast(32'h10000), rd, err, cyc);
    checks++;
    if (rd !== '0 || err !== exp_err || cyc !== 5) begin
      errors++; $display("FAIL op10_overflow lane0 got %h err %b want 0 err %b", rd[DW-1:0], err, exp_err);
    end
    do_task(4'd0, bcast(32'd1), bcast(32'd1), rd, err, cyc);
    checks++;
    if (rd !== bcast(32'd2) || err !== 1'b0) begin
      errors++; $display("FAIL add_before_illegal lane0 got %h err %b want 2 err 0", rd[DW-1:0], err);
    end
    do_task(4'd15, bcast(32'h1234), bcast(32'h55), rd, err, cyc);
    checks++;
    if (rd !== '0 || err !== 1'b1 || cyc !== 5) begin
      errors++; $display("FAIL op15 lane0 got %h err %b cyc %0d want 0 err 1 cyc 5", rd[DW-1:0], err, cyc);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [N-1:0] a, b, exp;
    logic [8*DW-1:0] exp_lo;
    logic [N-1:0] rd;
    logic err, seen;
    int cyc;
    for (int t = 0; t < TN; t++) begin
      a[t*DW +: DW] = DW'(t + 1);
      b[t*DW +: DW] = DW'(t);
      exp[t*DW +: DW] = DW'(t + 100);
    end
    for (int t = 0; t < 8; t++) exp_lo[t*DW +: DW] = DW'(2 * t + 1);
    task_op = 4'd0; task_rs1 = a; task_rs2 = b; task_valid = 1'b1;
    tick(); tick();
    checks++;
    if (task_rd[8*DW-1:0] !== exp_lo || task_rd[N-1:8*DW] !== '0) begin
      errors++; $display("FAIL midreset_chunk0 got %h want lo %h hi 0", task_rd, exp_lo);
    end
    rst_n = 1'b0; task_valid = 1'b0;
    tick();
    checks++;
    if (task_rd !== '0 || busy !== 1'b0 || task_done !== 1'b0) begin
      errors++; $display("FAIL midreset_state rd_lo %h busy %b done %b want 0 0 0", task_rd[DW-1:0], busy, task_done);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin tick(); if (task_done) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_done got %b want 0", seen); end
    do_task(4'd0, b, bcast(32'd100), rd, err, cyc);
    checks++;
    if (rd !== exp || err !== 1'b0 || cyc !== 5) begin
      errors++; $display("FAIL midreset_followup lane31 got %h cyc %0d want %h cyc 5", rd[N-1 -: DW], cyc, exp[N-1 -: DW]);
    end
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; task_valid = 1'b0; task_op = '0; task_rs1 = '0; task_rs2 = '0;
    test_reset();
    test_add();
    test_wrap_sign();
    test_stall();
    test_illegal();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gelato_compute_alu.md
Name: gelato_compute_alu

Overview:
SIMD integer ALU of the Gelato compute unit. It sits directly downstream of the compute scheduler and consumes its compute task (valid, op, rs1, rs2). It processes THREAD_NUM per-thread operand pairs over several cycles, LANES threads per cycle. It returns the packed per-thread result on rd with a one-cycle done pulse.

Parameters:
THREAD_NUM, 32, threads per warp; must be an integer multiple of LANES
DATA_WIDTH, 32, bits per thread operand/result
LANES, 8, threads computed per cycle; BUSY lasts THREAD_NUM/LANES cycles

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
rdy  input  1  global enable; when low, all state and outputs hold
task_valid  input  1  task request; held high by the scheduler until it samples done
task_op  input  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL (optional); others illegal
task_rs1  input  THREAD_NUM*DATA_WIDTH  operand A; thread t occupies bits [t*DATA_WIDTH +: DATA_WIDTH]
task_rs2  input  THREAD_NUM*DATA_WIDTH  operand B; same packing
task_done  output  1  one-cycle pulse: rd is valid
task_rd  output  THREAD_NUM*DATA_WIDTH  packed result; same packing
task_err  output  1  pulses with task_done when op was illegal
busy  output  1  high in BUSY and DONE states

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-low on rst_n. Reset is sampled on posedge clk and takes priority over rdy.
- Reset values: state=IDLE, chunk=0, task_done=0, task_err=0, task_rd=0, busy=0.
- rdy=0: no register changes, including the chunk counter, done, and state.
- States: IDLE, BUSY, DONE.
  - IDLE: on the edge with task_valid=1, latch op, rs1 and rs2 into internal registers, clear chunk to 0, and go to BUSY. Later input changes do not affect the task in flight.
  - BUSY: each cycle, compute threads chunk*LANES .. chunk*LANES+LANES-1 from the latched operands and write them into task_rd, then increment chunk.
  - BUSY, last chunk (chunk == THREAD_NUM/LANES-1): write it, set task_done=1, set task_err to the illegal-op flag, and go to DONE.
  - DONE: task_done and task_err are cleared on the next enabled edge. Stay in DONE while task_valid=1. Go to IDLE on the first enabled edge with task_valid=0, so a held-high valid is never re-accepted.
- Latency: acceptance edge to task_done high is THREAD_NUM/LANES cycles (4 at defaults). Back-to-back throughput is one task per THREAD_NUM/LANES+2 cycles, with the scheduler dropping valid one cycle after done.
- task_rd is stable from done until the BUSY cycle of the next task. Lanes not yet rewritten keep their old values during BUSY.
- Arithmetic is per thread, modulo 2^DATA_WIDTH:
  - ADD/SUB wrap.
  - Shifts use rs2[$clog2(DATA_WIDTH)-1:0] only.
  - SRA is arithmetic.
  - SLT is signed and SLTU is unsigned; both give 1 or 0, zero-extended.
- Illegal op: every lane result is 0 and task_err pulses with task_done; the timing is unchanged.
- Reset mid-BUSY: return to IDLE next edge with task_rd=0. A pending task is dropped and task_done is not raised.
- task_valid dropping during BUSY is ignored; the task completes.

Optional Feature:
GELATO_ALU_MUL_EN
- Defined: op 10 = MUL, the low DATA_WIDTH bits of the unsigned product rs1*rs2 per thread. Same single-cycle-per-chunk timing.
- Undefined: no multiplier is instantiated. Op 10 is illegal (zero results, task_err=1).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with task_valid=1 -> state IDLE, task_done=0, task_rd=0, no acceptance until rst_n=1.
- ADD (rs2 = imm broadcast): rs1 thread t = t, rs2 all = 5, op=0 -> after 4 cycles task_done pulses 1 cycle, thread t rd = t+5. Valid held through DONE does not restart the task.
- Wrap/sign: rs1=0xFFFFFFFF, rs2=1 -> ADD gives 0; SLT gives 1 (-1<1); SLTU gives 0; SRA by 4 of 0x80000000 gives 0xF8000000.
- rdy stall: deassert rdy for 3 cycles mid-BUSY -> task_done arrives exactly 3 cycles later and the result is correct.
- Illegal op 15 -> task_done and task_err pulse together, rd all 0. Op 10 without GELATO_ALU_MUL_EN behaves the same; with it, 7*6 gives 42 and 0x10000*0x10000 gives 0.
- Reset asserted in the second BUSY cycle -> no done pulse, rd=0. A new ADD task afterwards completes normally.
